// File: rtl/tx_arbiter.sv
// Round-robin arbiter that lets NREQ byte-stream requesters share one UART Sender.
// A granted requester keeps the Sender for a packet: until reqLast, MAX_BURST bytes, or LOCK_IDLE idle cycles.
module tx_arbiter #(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned BUSY_TIMEOUT = 4,
  parameter int unsigned LOCK_IDLE    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] reqData,
  input  logic [NREQ-1:0]   reqLast,
  output logic [NREQ-1:0]   reqAck,
  output logic [NREQ-1:0]   grant,
  output logic              doTransmit,
  output logic [7:0]        TxData,
  input  logic              isBusy,
  output logic              txTimeout
);

  localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam int unsigned IDLE_W  = (LOCK_IDLE > 1) ? $clog2(LOCK_IDLE + 1) : 1;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               last_q, last_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               dotx_q, dotx_d;
  logic [7:0]         data_q, data_d;
  logic               tout_q, tout_d;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   cap_idx;
  logic [7:0]         cap_byte;
  logic [PTR_W-1:0]   owner_next;
  logic               do_cap;
  logic               do_end;
  int unsigned        scan_j;

  // First requesting index at or above rrPtr, wrapping modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_j    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_j = 32'(rr_q) + k;
      if (scan_j >= NREQ) scan_j = scan_j - NREQ;
      if (!sel_found && req[PTR_W'(scan_j)]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(scan_j);
      end
    end
  end

  // While locked only the owner may be captured.
  always_comb begin
    cap_idx = (state_q == LOCKED) ? owner_q : sel_idx;
  end

  always_comb begin
    cap_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (cap_idx == PTR_W'(i)) cap_byte = reqData[8*i +: 8];
    end
  end

  assign owner_next = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    to_d    = to_q;
    idle_d  = idle_q;
    last_d  = last_q;
    ack_d   = '0;
    grant_d = grant_q;
    dotx_d  = 1'b0;
    data_d  = data_q;
    tout_d  = 1'b0;
    do_cap  = 1'b0;
    do_end  = 1'b0;

    unique case (state_q)
      ARB: begin
        do_cap = !isBusy && sel_found;
      end
      WAIT_HI: begin
        if (isBusy) begin
          state_d = WAIT_LO;
          to_d    = '0;
        end else if (to_q == TO_W'(BUSY_TIMEOUT - 1)) begin
          tout_d = 1'b1;
          do_end = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      WAIT_LO: begin
        if (!isBusy) begin
          if (last_q || (burst_q == BURST_W'(MAX_BURST))) begin
            do_end = 1'b1;
          end else begin
            state_d = LOCKED;
            idle_d  = '0;
          end
        end
      end
      LOCKED: begin
        if (req[owner_q]) begin
          idle_d = '0;
          do_cap = !isBusy;
        end else if (idle_q == IDLE_W'(LOCK_IDLE - 1)) begin
          do_end = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: state_d = ARB;
    endcase

    if (do_cap) begin
      data_d           = cap_byte;
      dotx_d           = 1'b1;
      ack_d[cap_idx]   = 1'b1;
      grant_d          = '0;
      grant_d[cap_idx] = 1'b1;
      owner_d          = cap_idx;
      burst_d          = burst_q + BURST_W'(1);
      last_d           = reqLast[cap_idx];
      to_d             = '0;
      state_d          = WAIT_HI;
    end

    // Packet end: release the Sender and hand priority to the next requester.
    if (do_end) begin
      grant_d = '0;
      burst_d = '0;
      rr_d    = owner_next;
      to_d    = '0;
      idle_d  = '0;
      state_d = ARB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      rr_q    <= '0;
      owner_q <= '0;
      burst_q <= '0;
      to_q    <= '0;
      idle_q  <= '0;
      last_q  <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      dotx_q  <= 1'b0;
      data_q  <= 8'h00;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      dotx_q  <= dotx_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
    end
  end

  assign reqAck     = ack_q;
  assign grant      = grant_q;
  assign doTransmit = dotx_q;
  assign TxData     = data_q;
  assign txTimeout  = tout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized bench for tx_arbiter: requester and Sender models drive it, a packet-level
// reference model predicts every registered output each cycle.
module tb_tx_arbiter;

  localparam int unsigned NREQ         = 3;
  localparam int unsigned MAX_BURST    = 16;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned LOCK_IDLE    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] reqData;
  logic [NREQ-1:0]   reqLast;
  logic [NREQ-1:0]   reqAck;
  logic [NREQ-1:0]   grant;
  logic              doTransmit;
  logic [7:0]        TxData;
  logic              isBusy;
  logic              txTimeout;

  always #5 clk = ~clk;

  tx_arbiter #(
    .NREQ(NREQ), .MAX_BURST(MAX_BURST), .BUSY_TIMEOUT(BUSY_TIMEOUT), .LOCK_IDLE(LOCK_IDLE)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .reqData(reqData), .reqLast(reqLast),
    .reqAck(reqAck), .grant(grant), .doTransmit(doTransmit), .TxData(TxData),
    .isBusy(isBusy), .txTimeout(txTimeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (packet-level view of the arbiter) ----------------
  localparam int PH_FREE = 0;  // Sender unowned, waiting for a request
  localparam int PH_SENT = 1;  // byte handed over, Sender not yet busy
  localparam int PH_BUSY = 2;  // Sender busy with the byte
  localparam int PH_HELD = 3;  // packet open, waiting for owner's next byte

  int       phase, rr, owner, sent_in_pkt, wait_cycles, idle_cycles, pick;
  bit       pkt_last, pkt_done;
  logic [NREQ-1:0] e_ack, e_grant;
  logic            e_dotx, e_tout;
  logic [7:0]      e_data;
  int n_cap = 0, n_tout = 0, n_burst_end = 0, n_idle_end = 0;

  always @(posedge clk) begin
    if (reset) begin
      phase = PH_FREE; rr = 0; owner = 0; sent_in_pkt = 0; wait_cycles = 0; idle_cycles = 0;
      pkt_last = 1'b0; e_ack = '0; e_grant = '0; e_dotx = 1'b0; e_tout = 1'b0; e_data = 8'h00;
    end else begin
      pick = -1;
      pkt_done = 1'b0;
      e_ack = '0; e_dotx = 1'b0; e_tout = 1'b0;
      case (phase)
        PH_FREE: if (!isBusy) begin
          for (int k = 0; k < int'(NREQ); k++)
            if (pick < 0 && req[(rr + k) % NREQ]) pick = (rr + k) % NREQ;
        end
        PH_SENT: if (isBusy) phase = PH_BUSY;
          else begin
            wait_cycles++;
            if (wait_cycles >= int'(BUSY_TIMEOUT)) begin e_tout = 1'b1; pkt_done = 1'b1; n_tout++; end
          end
        PH_BUSY: if (!isBusy) begin
          if (pkt_last) pkt_done = 1'b1;
          else if (sent_in_pkt == int'(MAX_BURST)) begin pkt_done = 1'b1; n_burst_end++; end
          else begin phase = PH_HELD; idle_cycles = 0; end
        end
        default: if (req[owner]) begin
            idle_cycles = 0;
            if (!isBusy) pick = owner;
          end else begin
            idle_cycles++;
            if (idle_cycles >= int'(LOCK_IDLE)) begin pkt_done = 1'b1; n_idle_end++; end
          end
      endcase
      if (pick >= 0) begin
        e_data = reqData[8*pick +: 8];
        e_dotx = 1'b1;
        e_ack[pick] = 1'b1;
        e_grant = '0;
        e_grant[pick] = 1'b1;
        owner = pick;
        sent_in_pkt++;
        pkt_last = reqLast[pick];
        wait_cycles = 0;
        phase = PH_SENT;
        n_cap++;
      end
      if (pkt_done) begin
        e_grant = '0; sent_in_pkt = 0; rr = (owner + 1) % NREQ; phase = PH_FREE;
      end
    end
  end

  // ---------------- stimulus models ----------------
  int unsigned last_pct, drop_pct, drop_min, drop_max, noresp_pct, spur_pct, rst_pm;
  int gap [NREQ];
  int busy_dly = -1;
  int busy_len = 0;

  task automatic drive_inputs();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (reqAck[i]) begin
        req[i] = 1'b0;
        gap[i] = ($urandom_range(99) < drop_pct) ? int'($urandom_range(drop_max, drop_min)) : 0;
      end
      if (!req[i]) begin
        if (gap[i] == 0) begin
          req[i] = 1'b1;
          reqData[8*i +: 8] = 8'($urandom);
          reqLast[i] = ($urandom_range(99) < last_pct);
        end else begin
          gap[i]--;
          reqData[8*i +: 8] = 8'($urandom);
          reqLast[i] = 1'($urandom);
        end
      end
    end
    // Sender: busy some cycles after doTransmit, sometimes never, sometimes spuriously.
    if (isBusy) begin
      if (busy_len <= 1) isBusy = 1'b0;
      else busy_len--;
    end else if (busy_dly == 0) begin
      isBusy = 1'b1;
      busy_len = int'($urandom_range(6, 1));
      busy_dly = -1;
    end else if (busy_dly > 0) begin
      busy_dly--;
    end else if ($urandom_range(99) < spur_pct) begin
      busy_dly = 0;
    end
    if (doTransmit && ($urandom_range(99) >= noresp_pct)) busy_dly = int'($urandom_range(2, 0));
    reset = ($urandom_range(999) < rst_pm);
  endtask

  task automatic tick();
    @(negedge clk);
    check_eq("reqAck", 32'(reqAck), 32'(e_ack));
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("doTransmit", 32'(doTransmit), 32'(e_dotx));
    check_eq("TxData", 32'(TxData), 32'(e_data));
    check_eq("txTimeout", 32'(txTimeout), 32'(e_tout));
    drive_inputs();
  endtask

  task automatic run_phase(input int unsigned lp, input int unsigned dp, input int unsigned dmin,
                           input int unsigned dmax, input int unsigned nr, input int unsigned sp,
                           input int unsigned rp, input int cycles);
    last_pct = lp; drop_pct = dp; drop_min = dmin; drop_max = dmax;
    noresp_pct = nr; spur_pct = sp; rst_pm = rp;
    repeat (cycles) tick();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    reqData = '0;
    reqLast = '0;
    isBusy = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) gap[i] = int'($urandom_range(3, 0));
    last_pct = 30; drop_pct = 0; drop_min = 1; drop_max = 1;
    noresp_pct = 0; spur_pct = 0; rst_pm = 0;

    // reset values observed after the first edge, then hold reset one more edge
    @(negedge clk);
    check_eq("rst_reqAck", 32'(reqAck), 32'(0));
    check_eq("rst_grant", 32'(grant), 32'(0));
    check_eq("rst_TxData", 32'(TxData), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    run_phase(30, 20,  1, 12,   0, 2, 0, 1500);  // mixed traffic
    run_phase( 0,  0,  1,  1,   0, 0, 0,  800);  // endless packets hit the burst limit
    run_phase( 0, 100, 10, 25,  0, 0, 0,  800);  // owners go quiet while locked
    run_phase(50,  0,  1,  1, 100, 0, 0,  300);  // Sender never responds
    run_phase(25, 30,  1, 20,  15, 3, 5, 2000);  // everything, including resets

    check_eq("cov_captures", 32'(n_cap > 100), 32'(1));
    check_eq("cov_timeouts", 32'(n_tout > 0), 32'(1));
    check_eq("cov_burst_end", 32'(n_burst_end > 0), 32'(1));
    check_eq("cov_idle_end", 32'(n_idle_end > 0), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
